// File: rtl/uart_tx_arbiter_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the uart_tx arbiter: FSM state encoding, byte width
// and a helper that sizes saturating counters.
package uart_arb_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } arb_state_e;

  // Width able to hold 0..max_val; never zero so a disabled counter still has a bit.
  function automatic int cnt_width(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
`timescale 1ns/1ps
// Producer/serializer side signals of the arbiter, bundled in one interface.
// The arbiter uses the slave view; whatever drives it uses the master view.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import uart_arb_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        i_Req;
  logic [BYTE_W*NUM_REQ-1:0] i_Req_Byte;
  logic [NUM_REQ-1:0]        o_Req_Ack;
  logic                      o_Tx_DV;
  logic [BYTE_W-1:0]         o_Tx_Byte;
  logic                      i_Tx_Done;
  logic                      o_Busy;
  logic                      o_Sent;
  logic [IDX_W-1:0]          o_Sent_Id;
  logic                      o_Timeout;

  modport slave (
    input  i_Req, i_Req_Byte, i_Tx_Done,
    output o_Req_Ack, o_Tx_DV, o_Tx_Byte, o_Busy, o_Sent, o_Sent_Id, o_Timeout
  );

  modport master (
    output i_Req, i_Req_Byte, i_Tx_Done,
    input  o_Req_Ack, o_Tx_DV, o_Tx_Byte, o_Busy, o_Sent, o_Sent_Id, o_Timeout
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
`timescale 1ns/1ps
// Combinational round-robin finder: first set request searching upward from
// i_Ptr+1 with wrap-around.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_Req,
  input  logic [IDX_W-1:0]   i_Ptr,
  output logic               o_Valid,
  output logic [IDX_W-1:0]   o_Idx
);

  localparam logic [IDX_W:0] N_W = (IDX_W+1)'(NUM_REQ);

  logic [IDX_W-1:0]   cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] hit;

  // Candidate gi is the requester gi+1 places after the pointer, modulo NUM_REQ.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      localparam logic [IDX_W:0] OFS = (IDX_W+1)'(gi + 1);
      logic [IDX_W:0] sum;
      logic [IDX_W:0] wrapped;
      assign sum           = {1'b0, i_Ptr} + OFS;
      assign wrapped       = sum - N_W;
      assign cand_idx[gi]  = (sum >= N_W) ? wrapped[IDX_W-1:0] : sum[IDX_W-1:0];
      assign hit[gi]       = i_Req[cand_idx[gi]];
    end
  endgenerate

  // Walk from farthest to nearest so the nearest hit is the final assignment.
  always_comb begin
    o_Valid = 1'b0;
    o_Idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (hit[k]) begin
        o_Valid = 1'b1;
        o_Idx   = cand_idx[k];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// Shares one uart_tx serializer between NUM_REQ byte producers: round-robin
// pick, one-cycle launch, wait for Done or watchdog, then a guard gap.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 8192
) (
  input logic            i_Clock,
  input logic            i_Reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int GAP_W = cnt_width(GAP_CYCLES);
  localparam int TO_W  = cnt_width(TIMEOUT_CYCLES);

  localparam bit               GAP_EN   = (GAP_CYCLES > 0);
  localparam bit               TO_EN    = (TIMEOUT_CYCLES > 0);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_EN ? GAP_CYCLES - 1 : 0);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [TO_W-1:0]  TO_MAX   = {TO_W{1'b1}};
  localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(NUM_REQ - 1);

  arb_state_e        state_reg,   state_next;
  logic [IDX_W-1:0]  ptr_reg,     ptr_next;
  logic [TO_W-1:0]   to_cnt_reg,  to_cnt_next;
  logic [GAP_W-1:0]  gap_cnt_reg, gap_cnt_next;
  logic [BYTE_W-1:0] tx_byte_reg, tx_byte_next;
  logic [IDX_W-1:0]  sent_id_reg, sent_id_next;
  logic              sent_c;
  logic              timeout_c;
  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;
  logic [BYTE_W-1:0] req_bytes [NUM_REQ];

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .i_Req   (bus.i_Req),
    .i_Ptr   (ptr_reg),
    .o_Valid (pick_valid),
    .o_Idx   (pick_idx)
  );

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_bytes[gi]     = bus.i_Req_Byte[gi*BYTE_W +: BYTE_W];
      assign bus.o_Req_Ack[gi] = (state_reg == LAUNCH) && (sent_id_reg == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_reg   <= IDLE;
      ptr_reg     <= PTR_RST;
      to_cnt_reg  <= '0;
      gap_cnt_reg <= '0;
      tx_byte_reg <= '0;
      sent_id_reg <= '0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      to_cnt_reg  <= to_cnt_next;
      gap_cnt_reg <= gap_cnt_next;
      tx_byte_reg <= tx_byte_next;
      sent_id_reg <= sent_id_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    to_cnt_next  = to_cnt_reg;
    gap_cnt_next = gap_cnt_reg;
    tx_byte_next = tx_byte_reg;
    sent_id_next = sent_id_reg;
    sent_c       = 1'b0;
    timeout_c    = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          sent_id_next = pick_idx;
          tx_byte_next = req_bytes[pick_idx];
          state_next   = LAUNCH;
        end
      end
      LAUNCH: begin
        ptr_next    = sent_id_reg;
        to_cnt_next = '0;
        state_next  = WAIT_DONE;
      end
      WAIT_DONE: begin
        // Done takes precedence over a watchdog expiry in the same cycle.
        if (bus.i_Tx_Done) begin
          sent_c       = 1'b1;
          gap_cnt_next = '0;
          state_next   = GAP_EN ? GAP : IDLE;
        end else if (TO_EN && (to_cnt_reg == TO_LAST)) begin
          timeout_c    = 1'b1;
          gap_cnt_next = '0;
          state_next   = GAP_EN ? GAP : IDLE;
        end else if (to_cnt_reg != TO_MAX) begin
          to_cnt_next = to_cnt_reg + 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          state_next = IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.o_Tx_DV   = (state_reg == LAUNCH);
  assign bus.o_Tx_Byte = tx_byte_reg;
  assign bus.o_Sent_Id = sent_id_reg;
  assign bus.o_Busy    = (state_reg != IDLE);
  assign bus.o_Sent    = sent_c;
  assign bus.o_Timeout = timeout_c;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
// Bench for uart_tx_arbiter: directed scenarios followed by randomized traffic,
// checked against a transaction-level round-robin model with a stubbed Done.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ        = 4;
  localparam int GAP_CYCLES     = 2;
  localparam int TIMEOUT_CYCLES = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [NUM_REQ-1:0] req_v;
  logic [7:0]         bytes_v [NUM_REQ];
  int                 last_id;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .GAP_CYCLES     (GAP_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  always #2.5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) bus.i_Req_Byte[8*i +: 8] = bytes_v[i];
    bus.i_Req = req_v;
  endtask

  // New requesters get a fresh random byte; already-pending ones keep theirs.
  task automatic add_reqs(input logic [NUM_REQ-1:0] add);
    for (int i = 0; i < NUM_REQ; i++)
      if (add[i] && !req_v[i]) bytes_v[i] = 8'($urandom);
    req_v = req_v | add;
    drive();
  endtask

  // Round-robin reference: first pending requester after the last one served.
  function automatic int rr_model(input logic [NUM_REQ-1:0] req, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int i;
      i = (last + k) % NUM_REQ;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},    32'(bus.o_Busy),      32'd0);
    check({tag, "_dv"},      32'(bus.o_Tx_DV),     32'd0);
    check({tag, "_ack"},     32'(bus.o_Req_Ack),   32'd0);
    check({tag, "_byte"},    32'(bus.o_Tx_Byte),   32'd0);
    check({tag, "_id"},      32'(bus.o_Sent_Id),   32'd0);
    check({tag, "_sent"},    32'(bus.o_Sent),      32'd0);
    check({tag, "_timeout"}, 32'(bus.o_Timeout),   32'd0);
  endtask

  // One full transfer starting from an IDLE cycle with requests already driven.
  // dly < TIMEOUT_CYCLES: Done arrives dly cycles into WAIT_DONE; otherwise none.
  task automatic serve_one(input int dly, input bit keep, input bit stray);
    int         exp_id;
    logic [7:0] exp_byte;
    exp_id   = rr_model(req_v, last_id);
    exp_byte = bytes_v[exp_id];
    step();
    check("launch_dv",   32'(bus.o_Tx_DV),   32'd1);
    check("launch_ack",  32'(bus.o_Req_Ack), 32'(1 << exp_id));
    check("launch_byte", 32'(bus.o_Tx_Byte), 32'(exp_byte));
    check("launch_id",   32'(bus.o_Sent_Id), 32'(exp_id));
    last_id = exp_id;
    if (!keep) begin
      req_v[exp_id] = 1'b0;
      drive();
    end
    step();
    check("post_dv",  32'(bus.o_Tx_DV),   32'd0);
    check("post_ack", 32'(bus.o_Req_Ack), 32'd0);
    for (int k = 1; k <= TIMEOUT_CYCLES; k++) begin
      if (k > 1) step();
      if (k == dly + 1) bus.i_Tx_Done = 1'b1;
      #1;
      check($sformatf("wait_sent_%0d", k), 32'(bus.o_Sent), 32'(k == dly + 1));
      check($sformatf("wait_timeout_%0d", k), 32'(bus.o_Timeout),
            32'((k == TIMEOUT_CYCLES) && (k != dly + 1)));
      if (k == dly + 1 || k == TIMEOUT_CYCLES) break;
    end
    check("end_id", 32'(bus.o_Sent_Id), 32'(exp_id));
    step();
    bus.i_Tx_Done = 1'b0;
    for (int g = 1; g <= GAP_CYCLES; g++) begin
      if (g > 1) step();
      if (stray && g == 1) bus.i_Tx_Done = 1'b1;
      #1;
      check("gap_busy", 32'(bus.o_Busy),  32'd1);
      check("gap_dv",   32'(bus.o_Tx_DV), 32'd0);
      check("gap_sent", 32'(bus.o_Sent),  32'd0);
      bus.i_Tx_Done = 1'b0;
    end
    step();
    check("idle_busy", 32'(bus.o_Busy),    32'd0);
    check("idle_dv",   32'(bus.o_Tx_DV),   32'd0);
    check("hold_byte", 32'(bus.o_Tx_Byte), 32'(exp_byte));
    check("hold_id",   32'(bus.o_Sent_Id), 32'(exp_id));
  endtask

  initial begin
    logic [NUM_REQ-1:0] add;
    req_v = '0;
    for (int i = 0; i < NUM_REQ; i++) bytes_v[i] = 8'h00;
    drive();
    bus.i_Tx_Done = 1'b0;
    last_id = NUM_REQ - 1;

    // Reset state
    step();
    check_all_zero("in_reset");
    rst = 1'b0;
    step();
    check_all_zero("after_reset");

    // Single request with a known byte
    bytes_v[0] = 8'hA3;
    req_v = 4'b0001;
    drive();
    serve_one(5, 1'b0, 1'b1);

    // Watchdog abort on requester 3, Done never arrives
    add_reqs(4'b1000);
    serve_one(TIMEOUT_CYCLES + 5, 1'b0, 1'b0);

    // All four together, held until acknowledged
    bytes_v[0] = 8'h11; bytes_v[1] = 8'h22; bytes_v[2] = 8'h33; bytes_v[3] = 8'h44;
    req_v = 4'b1111;
    drive();
    for (int n = 0; n < NUM_REQ; n++) serve_one(n + 1, 1'b0, 1'b0);

    // Fairness with two permanently requesting producers
    add_reqs(4'b0101);
    for (int n = 0; n < 4; n++) serve_one(2, 1'b1, 1'b0);
    req_v = '0;
    drive();

    // Done coincides with the watchdog expiry
    add_reqs(4'b0010);
    serve_one(TIMEOUT_CYCLES - 1, 1'b0, 1'b0);

    // Randomized traffic
    for (int t = 0; t < 30; t++) begin
      add = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
      if ((req_v | add) == '0) add = NUM_REQ'(1 << $urandom_range(0, NUM_REQ - 1));
      add_reqs(add);
      serve_one(int'($urandom_range(0, TIMEOUT_CYCLES + 4)), 1'b0, 1'($urandom_range(0, 1)));
    end

    // Reset during WAIT_DONE
    req_v = '0;
    add_reqs(4'b0010);
    step();
    check("rst_launch_ack", 32'(bus.o_Req_Ack), 32'(1 << rr_model(4'b0010, last_id)));
    req_v = '0;
    drive();
    step();
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    step();
    rst = 1'b0;
    last_id = NUM_REQ - 1;
    step();
    bus.i_Tx_Done = 1'b1;
    #1;
    check("stray_done_sent", 32'(bus.o_Sent), 32'd0);
    check("stray_done_busy", 32'(bus.o_Busy), 32'd0);
    step();
    bus.i_Tx_Done = 1'b0;
    add_reqs(4'b1111);
    serve_one(3, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
